// File: rtl/gated_decim_pkg.sv
// ----------------------------------------------------------------------------
// gated_decim_pkg
//   Shared definitions for the gated decimation control block: settings-bus
//   register offsets, CTRL field positions, gate mode encodings and the gate
//   FSM state type.
//   No ports (package).
// ----------------------------------------------------------------------------
package gated_decim_pkg;

    // Register offsets relative to ADDR_BASE. RATE[c] sits at RATE_OFS + c,
    // the window length register directly follows the last RATE register.
    localparam int CTRL_OFS = 0;
    localparam int RATE_OFS = 1;

    // CTRL register field positions
    localparam int CTRL_ENABLE_RX_BIT  = 1;
    localparam int CTRL_DSP_RESET_BIT  = 3;
    localparam int CTRL_MODE_BIT       = 4;
    localparam int CTRL_CLR_MISSED_BIT = 7;   // write-1 action, not stored

    // Gate modes (CTRL[4])
    localparam logic MODE_LEVEL  = 1'b0;
    localparam logic MODE_WINDOW = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } gate_state_t;

    // Absolute settings-bus address of a register at offset ofs from base.
    function automatic logic [6:0] reg_addr(input logic [6:0] base, input int ofs);
        return base + 7'(ofs);
    endfunction

endpackage

// File: rtl/gated_decim_ctrl_ch.sv
// ----------------------------------------------------------------------------
// decim_strobe_ch
//   One decimation channel: a reload counter plus the registered strobe.
//   While i_run is high a strobe is issued whenever the counter is zero and
//   the counter reloads R-1 (R = max(i_rate,1)); otherwise it decrements.
//   Outside run the counter is parked at zero so the first run cycle strobes.
//   A new i_rate is only picked up at the next reload.
//
// Ports
//   i_clk       system clock
//   i_rst       asynchronous active-high reset
//   i_run       channel may strobe this cycle
//   i_clear     force counter to zero and suppress the strobe
//   i_rate      programmed decimation rate (0 treated as 1)
//   o_strobe    registered decimation strobe
//   o_cnt_zero  counter is zero (a strobe is issued next edge if i_run)
// ----------------------------------------------------------------------------
module decim_strobe_ch #(
    parameter int RATE_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_run,
    input  logic              i_clear,
    input  logic [RATE_W-1:0] i_rate,
    output logic              o_strobe,
    output logic              o_cnt_zero
);

    logic [RATE_W-1:0] r_cnt;
    logic              r_strobe;
    logic [RATE_W-1:0] w_reload;

    // Rate 0 behaves like rate 1: reload value 0 gives a strobe every cycle.
    assign w_reload   = (i_rate == '0) ? '0 : i_rate - RATE_W'(1);
    assign o_cnt_zero = (r_cnt == '0);
    assign o_strobe   = r_strobe;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_strobe <= 1'b0;
        end else if (i_clear || !i_run) begin
            r_cnt    <= '0;
            r_strobe <= 1'b0;
        end else if (r_cnt == '0) begin
            r_cnt    <= w_reload;
            r_strobe <= 1'b1;
        end else begin
            r_cnt    <= r_cnt - RATE_W'(1);
            r_strobe <= 1'b0;
        end
    end

endmodule

// File: rtl/gated_decim_ctrl.sv
// ----------------------------------------------------------------------------
// gated_decim_ctrl
//   Settings-bus decoder and gated decimation strobe generator. Decodes CTRL,
//   per-channel RATE and WIN registers, conditions the external gate, runs the
//   IDLE/ARMED/RUN/DONE gate FSM and drives NUM_CHAN phase-aligned strobes.
//
// Configuration macro
//   GATED_DECIM_GATE_SYNC_EN : when defined, gate_enable passes through a
//   two-flop synchroniser; when undefined it is assumed synchronous to
//   master_clk and goes straight to edge detection (2 cycles less latency).
//
// Ports
//   master_clk     system clock
//   reset          asynchronous active-high reset
//   serial_addr    settings address
//   serial_data    settings data
//   serial_strobe  one-cycle write strobe
//   gate_enable    external gate
//   enable_rx      CTRL[1]
//   rx_dsp_reset   CTRL[3]
//   decim_rate     packed per-channel rates, channel 0 in the LSBs
//   strobe_decim   per-channel decimation strobes
//   gate_active    FSM is in RUN
//   window_done    one-cycle pulse on RUN->DONE
//   gate_missed    sticky flag: a window-mode gate rise was ignored
// ----------------------------------------------------------------------------
module gated_decim_ctrl
    import gated_decim_pkg::*;
#(
    parameter int         NUM_CHAN  = 2,
    parameter int         RATE_W    = 8,
    parameter int         WIN_W     = 16,
    parameter logic [6:0] ADDR_BASE = 7'd64
) (
    input  logic                       master_clk,
    input  logic                       reset,
    input  logic [6:0]                 serial_addr,
    input  logic [31:0]                serial_data,
    input  logic                       serial_strobe,
    input  logic                       gate_enable,
    output logic                       enable_rx,
    output logic                       rx_dsp_reset,
    output logic [NUM_CHAN*RATE_W-1:0] decim_rate,
    output logic [NUM_CHAN-1:0]        strobe_decim,
    output logic                       gate_active,
    output logic                       window_done,
    output logic                       gate_missed
);

    // ------------------------------------------------------------------
    // Settings registers
    // ------------------------------------------------------------------
    logic              r_enable_rx;
    logic              r_dsp_reset;
    logic              r_mode;
    logic [WIN_W-1:0]  r_win;
    logic [RATE_W-1:0] r_rate [NUM_CHAN];

    logic                w_ctrl_wr;
    logic                w_win_wr;
    logic [NUM_CHAN-1:0] w_rate_wr;

    assign w_ctrl_wr = serial_strobe && (serial_addr == reg_addr(ADDR_BASE, CTRL_OFS));
    assign w_win_wr  = serial_strobe &&
                       (serial_addr == reg_addr(ADDR_BASE, RATE_OFS + NUM_CHAN));

    for (genvar gc = 0; gc < NUM_CHAN; gc++) begin : g_rate_dec
        assign w_rate_wr[gc] = serial_strobe &&
                               (serial_addr == reg_addr(ADDR_BASE, RATE_OFS + gc));
    end

    always_ff @(posedge master_clk or posedge reset) begin
        if (reset) begin
            r_enable_rx <= 1'b0;
            r_dsp_reset <= 1'b0;
            r_mode      <= MODE_LEVEL;
            r_win       <= '0;
            for (int unsigned c = 0; c < NUM_CHAN; c++) begin
                r_rate[c] <= '0;
            end
        end else begin
            if (w_ctrl_wr) begin
                r_enable_rx <= serial_data[CTRL_ENABLE_RX_BIT];
                r_dsp_reset <= serial_data[CTRL_DSP_RESET_BIT];
                r_mode      <= serial_data[CTRL_MODE_BIT];
            end
            if (w_win_wr) begin
                r_win <= serial_data[WIN_W-1:0];
            end
            for (int unsigned c = 0; c < NUM_CHAN; c++) begin
                if (w_rate_wr[c]) begin
                    r_rate[c] <= serial_data[RATE_W-1:0];
                end
            end
        end
    end

    assign enable_rx    = r_enable_rx;
    assign rx_dsp_reset = r_dsp_reset;

    always_comb begin
        decim_rate = '0;
        for (int unsigned c = 0; c < NUM_CHAN; c++) begin
            decim_rate[c*RATE_W +: RATE_W] = r_rate[c];
        end
    end

    // ------------------------------------------------------------------
    // Gate conditioning: optional synchroniser, edge detect, registered
    // rise/fall pulses
    // ------------------------------------------------------------------
    logic w_g;
    logic r_g_d;
    logic r_rise;
    logic r_fall;

`ifdef GATED_DECIM_GATE_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge master_clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= gate_enable;
            r_sync2 <= r_sync1;
        end
    end

    assign w_g = r_sync2;
`else
    assign w_g = gate_enable;
`endif

    always_ff @(posedge master_clk or posedge reset) begin
        if (reset) begin
            r_g_d  <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_g_d  <= w_g;
            r_rise <= w_g & ~r_g_d;
            r_fall <= ~w_g & r_g_d;
        end
    end

    // ------------------------------------------------------------------
    // Gate FSM
    // ------------------------------------------------------------------
    gate_state_t r_state;
    gate_state_t w_state_nxt;
    logic        w_start;     // ARMED -> RUN this edge
    logic        w_win_end;   // RUN -> DONE this edge
    logic        w_win_zero;
    logic        w_win_full;
    logic        w_run;
    logic        w_clear;
    logic        w_missed_set;
    logic [WIN_W-1:0] r_win_cnt;

    assign w_win_zero = (r_win == '0);
    // Window is full once WIN channel-0 strobes have been issued; from that
    // edge on no channel may strobe even though RUN lasts one more cycle.
    assign w_win_full = (r_mode == MODE_WINDOW) && !w_win_zero && (r_win_cnt == r_win);

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_win_end   = 1'b0;
        if (!r_enable_rx || r_dsp_reset) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_ARMED;
                end
                ST_ARMED: begin
                    if (r_rise) begin
                        w_state_nxt = ST_RUN;
                        w_start     = 1'b1;
                    end
                end
                ST_RUN: begin
                    // Level mode and zero-length windows follow the gate;
                    // a real window ignores the gate until it completes.
                    if (r_mode == MODE_LEVEL || w_win_zero) begin
                        if (r_fall) begin
                            w_state_nxt = ST_ARMED;
                        end
                    end else if (w_win_full) begin
                        w_state_nxt = ST_DONE;
                        w_win_end   = 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!r_g_d) begin
                        w_state_nxt = ST_ARMED;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge master_clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign gate_active = (r_state == ST_RUN);

    // ------------------------------------------------------------------
    // Decimation channels
    // ------------------------------------------------------------------
    logic [NUM_CHAN-1:0] w_strobe;
    logic [NUM_CHAN-1:0] w_cnt_zero;

    assign w_run   = (r_state == ST_RUN) && !w_win_full && !r_dsp_reset;
    assign w_clear = r_dsp_reset || w_start;

    for (genvar gc = 0; gc < NUM_CHAN; gc++) begin : g_chan
        decim_strobe_ch #(
            .RATE_W (RATE_W)
        ) u_ch (
            .i_clk      (master_clk),
            .i_rst      (reset),
            .i_run      (w_run),
            .i_clear    (w_clear),
            .i_rate     (r_rate[gc]),
            .o_strobe   (w_strobe[gc]),
            .o_cnt_zero (w_cnt_zero[gc])
        );
    end

    assign strobe_decim = w_strobe;

    // ------------------------------------------------------------------
    // Window counter, window_done pulse, gate_missed flag
    // ------------------------------------------------------------------
    logic r_window_done;
    logic r_gate_missed;

    assign w_missed_set = r_rise && (r_mode == MODE_WINDOW) &&
                          ((r_state == ST_RUN) || (r_state == ST_DONE));

    always_ff @(posedge master_clk or posedge reset) begin
        if (reset) begin
            r_win_cnt     <= '0;
            r_window_done <= 1'b0;
            r_gate_missed <= 1'b0;
        end else begin
            r_window_done <= w_win_end;

            // Counts channel-0 strobes as they are registered.
            if (w_clear || (r_state != ST_RUN)) begin
                r_win_cnt <= '0;
            end else if (w_run && w_cnt_zero[0]) begin
                r_win_cnt <= r_win_cnt + WIN_W'(1);
            end

            if (w_ctrl_wr && serial_data[CTRL_CLR_MISSED_BIT]) begin
                r_gate_missed <= 1'b0;
            end else if (w_missed_set) begin
                r_gate_missed <= 1'b1;
            end
        end
    end

    assign window_done = r_window_done;
    assign gate_missed = r_gate_missed;

    // Only channel 0's counter state feeds the window logic.
    logic w_unused;
    assign w_unused = ^{serial_data, w_cnt_zero};

endmodule

// File: tb/tb_gated_decim_ctrl.sv
// ----------------------------------------------------------------------------
// tb_gated_decim_ctrl
//   Scoreboard bench for gated_decim_ctrl. Expected strobe and window_done
//   cycles are derived from the gate timing and rate rules and queued when a
//   gate is started; a monitor pops and compares whenever the DUT pulses.
// ----------------------------------------------------------------------------
module tb_gated_decim_ctrl;

    localparam logic [6:0] AB = 7'd64;
`ifdef GATED_DECIM_GATE_SYNC_EN
    localparam int D = 2;
`else
    localparam int D = 0;
`endif

    logic        master_clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  serial_addr = '0;
    logic [31:0] serial_data = '0;
    logic        serial_strobe = 1'b0;
    logic        gate_enable = 1'b0;
    logic        enable_rx;
    logic        rx_dsp_reset;
    logic [15:0] decim_rate;
    logic [1:0]  strobe_decim;
    logic        gate_active;
    logic        window_done;
    logic        gate_missed;

    gated_decim_ctrl #(
        .NUM_CHAN  (2),
        .RATE_W    (8),
        .WIN_W     (16),
        .ADDR_BASE (AB)
    ) dut (
        .master_clk    (master_clk),
        .reset         (reset),
        .serial_addr   (serial_addr),
        .serial_data   (serial_data),
        .serial_strobe (serial_strobe),
        .gate_enable   (gate_enable),
        .enable_rx     (enable_rx),
        .rx_dsp_reset  (rx_dsp_reset),
        .decim_rate    (decim_rate),
        .strobe_decim  (strobe_decim),
        .gate_active   (gate_active),
        .window_done   (window_done),
        .gate_missed   (gate_missed)
    );

    always #5 master_clk = ~master_clk;

    // cyc = index of the most recent rising edge
    int cyc = 0;
    always @(posedge master_clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    int exp_q0[$];
    int exp_q1[$];
    int exp_done[$];

    function automatic int eff(input int r);
        return (r == 0) ? 1 : r;
    endfunction

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic monitor_step();
        int e;
        if (!reset) begin
            if (strobe_decim[0]) begin
                n_cmp++;
                if (exp_q0.size() == 0) begin
                    n_err++;
                    $display("FAIL strobe0: strobe at cycle %0d, expected none", cyc);
                end else begin
                    e = exp_q0.pop_front();
                    if (e != cyc) begin
                        n_err++;
                        $display("FAIL strobe0: strobe at cycle %0d, expected cycle %0d", cyc, e);
                    end
                end
            end
            if (strobe_decim[1]) begin
                n_cmp++;
                if (exp_q1.size() == 0) begin
                    n_err++;
                    $display("FAIL strobe1: strobe at cycle %0d, expected none", cyc);
                end else begin
                    e = exp_q1.pop_front();
                    if (e != cyc) begin
                        n_err++;
                        $display("FAIL strobe1: strobe at cycle %0d, expected cycle %0d", cyc, e);
                    end
                end
            end
            if (window_done) begin
                n_cmp++;
                if (exp_done.size() == 0) begin
                    n_err++;
                    $display("FAIL window_done: pulse at cycle %0d, expected none", cyc);
                end else begin
                    e = exp_done.pop_front();
                    if (e != cyc) begin
                        n_err++;
                        $display("FAIL window_done: pulse at cycle %0d, expected cycle %0d", cyc, e);
                    end
                end
            end
        end
    endtask

    task automatic check_drained(input string tag);
        check_eq({tag, "_missing_strobe0"}, 64'(exp_q0.size()), 0);
        check_eq({tag, "_missing_strobe1"}, 64'(exp_q1.size()), 0);
        check_eq({tag, "_missing_done"},    64'(exp_done.size()), 0);
        exp_q0.delete();
        exp_q1.delete();
        exp_done.delete();
    endtask

    task automatic push_range(input int ch, input int first, input int last, input int step);
        for (int e = first; e <= last; e += step) begin
            if (ch == 0) exp_q0.push_back(e);
            else         exp_q1.push_back(e);
        end
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge master_clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge master_clk);
    endtask

    task automatic write_reg(input logic [6:0] addr, input logic [31:0] data);
        @(negedge master_clk);
        serial_addr   = addr;
        serial_data   = data;
        serial_strobe = 1'b1;
        @(negedge master_clk);
        serial_strobe = 1'b0;
    endtask

    // Raise the gate before the next rising edge, whose index is returned.
    task automatic start_gate(output int k);
        @(negedge master_clk);
        k = cyc + 1;
        gate_enable = 1'b1;
    endtask

    // Gate held high for len edges; strobes on every R-th RUN cycle, RUN
    // spanning edges k+D+2 .. k+len+D+1.
    task automatic do_level(input int r0, input int r1, input int len);
        int k;
        write_reg(AB + 7'd1, 32'(r0));
        write_reg(AB + 7'd2, 32'(r1));
        idle(2);
        start_gate(k);
        push_range(0, k + D + 2, k + len + D + 1, eff(r0));
        push_range(1, k + D + 2, k + len + D + 1, eff(r1));
        wait_until(k + D);
        check_eq("level_active_before_run", gate_active, 0);
        wait_until(k + D + 1);
        check_eq("level_active_in_run", gate_active, 1);
        wait_until(k + len - 1);
        gate_enable = 1'b0;
        wait_until(k + len + D);
        check_eq("level_active_at_fall", gate_active, 1);
        wait_until(k + len + D + 1);
        check_eq("level_active_after_fall", gate_active, 0);
        idle(6);
        check_drained("level");
    endtask

    // Window of win channel-0 strobes; gate held for 100 edges. With missed
    // set, the gate dips and rises again while the window is running.
    task automatic do_window(input int r0, input int r1, input int win, input bit missed);
        int k, s, t;
        write_reg(AB + 7'd3, 32'(win));
        write_reg(AB + 7'd1, 32'(r0));
        write_reg(AB + 7'd2, 32'(r1));
        write_reg(AB, 32'h12);
        idle(2);
        start_gate(k);
        s = k + D + 2;
        t = s + (win - 1) * eff(r0);
        push_range(0, s, t, eff(r0));
        push_range(1, s, t, eff(r1));
        exp_done.push_back(t + 1);
        wait_until(k + D + 1);
        check_eq("window_active_in_run", gate_active, 1);
        if (missed) begin
            wait_until(k + 5);
            gate_enable = 1'b0;
            wait_until(k + 7);
            gate_enable = 1'b1;
        end
        wait_until(t);
        check_eq("window_active_last_strobe", gate_active, 1);
        wait_until(t + 1);
        check_eq("window_active_in_done", gate_active, 0);
        wait_until(k + 99);
        check_eq("window_still_done", gate_active, 0);
        check_eq("window_gate_missed", gate_missed, 64'(missed));
        gate_enable = 1'b0;
        idle(6);
        check_drained("window");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int k, w, s;
        fork
            forever begin
                @(negedge master_clk);
                monitor_step();
            end
        join_none

        // Reset state
        idle(3);
        reset = 1'b0;
        check_eq("reset_outputs",
                 {enable_rx, rx_dsp_reset, decim_rate, strobe_decim,
                  gate_active, window_done, gate_missed}, 0);

        // Level mode
        write_reg(AB, 32'h02);
        check_eq("enable_rx_after_write", enable_rx, 1);
        check_eq("dsp_reset_after_write", rx_dsp_reset, 0);
        do_level(4, 2, 20);
        for (int i = 0; i < 3; i++) begin
            do_level(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                     int'($urandom_range(5, 16)));
        end
        do_level(0, 1, 6);
        do_level(1, 0, 6);

        // Window mode
        do_window(3, 2, 5, 1'b0);
        for (int i = 0; i < 2; i++) begin
            do_window(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)),
                      int'($urandom_range(1, 4)), 1'b0);
        end
        do_window(3, 1, 5, 1'b1);
        write_reg(AB, 32'h92);
        check_eq("gate_missed_cleared", gate_missed, 0);

        // Window mode with WIN=0 follows the gate like level mode
        write_reg(AB + 7'd3, 32'h0);
        do_level(2, 3, 8);

        // rx_dsp_reset mid-RUN
        write_reg(AB, 32'h02);
        write_reg(AB + 7'd1, 32'd1);
        write_reg(AB + 7'd2, 32'd3);
        idle(2);
        start_gate(k);
        w = k + D + 6;
        push_range(0, k + D + 2, w, 1);
        push_range(1, k + D + 2, w, 3);
        wait_until(w - 1);
        serial_addr   = AB;
        serial_data   = 32'h0A;
        serial_strobe = 1'b1;
        @(negedge master_clk);
        serial_strobe = 1'b0;
        check_eq("dsp_reset_output", rx_dsp_reset, 1);
        check_eq("dsp_reset_active_same_cycle", gate_active, 1);
        wait_until(w + 1);
        check_eq("dsp_reset_active_after", gate_active, 0);
        idle(4);
        check_drained("dsp_reset");
        check_eq("dsp_reset_rates_kept", decim_rate, 16'h0301);
        gate_enable = 1'b0;
        write_reg(AB, 32'h02);
        idle(4);

        // Asynchronous reset mid-window
        write_reg(AB + 7'd3, 32'd5);
        write_reg(AB + 7'd1, 32'd3);
        write_reg(AB + 7'd2, 32'd2);
        write_reg(AB, 32'h12);
        idle(2);
        start_gate(k);
        s = k + D + 2;
        push_range(0, s, k + D + 7, 3);
        push_range(1, s, k + D + 7, 2);
        wait_until(k + D + 7);
        check_eq("pre_reset_active", gate_active, 1);
        #2 reset = 1'b1;
        #1;
        check_eq("async_reset_outputs",
                 {enable_rx, rx_dsp_reset, decim_rate, strobe_decim,
                  gate_active, window_done, gate_missed}, 0);
        gate_enable = 1'b0;
        idle(2);
        reset = 1'b0;
        idle(4);
        check_drained("async_reset");
        check_eq("rates_after_reset", decim_rate, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gated_decim_ctrl.md
# gated_decim_ctrl

Parametrised successor to the minimal master control block. It decodes the serial settings bus into RX enable, DSP reset, per-channel decimation rates and a gate window length. It generates NUM_CHAN phase-aligned decimation strobes that run only inside an external gate, in either level-gated or fixed-length-window mode. It sits between the serial control interface and the RX DSP chains, replacing the single-channel, level-only strobe path.

## Interface
- NUM_CHAN, 2: number of RX channels (1..4)
- RATE_W, 8: decimation rate width (8..16)
- WIN_W, 16: window length width in strobes
- ADDR_BASE, 7'd64: serial address of CTRL; RATE[c] at ADDR_BASE+1+c; WIN at ADDR_BASE+1+NUM_CHAN
- master_clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- serial_addr  in  7  settings address
- serial_data  in  32  settings data
- serial_strobe  in  1  one-cycle write strobe
- gate_enable  in  1  external gate, asynchronous to master_clk
- enable_rx  out  1  CTRL[1]
- rx_dsp_reset  out  1  CTRL[3]
- decim_rate  out  NUM_CHAN*RATE_W  packed per-channel rates, channel 0 in LSBs
- strobe_decim  out  NUM_CHAN  per-channel decimation strobes
- gate_active  out  1  high while FSM in RUN
- window_done  out  1  one-cycle pulse on RUN->DONE
- gate_missed  out  1  sticky: gate rise ignored

## Operation
- Writes: serial_strobe with serial_addr matching a register loads serial_data (LSBs) into it. CTRL fields: [1] enable_rx, [3] rx_dsp_reset, [4] mode (0 level, 1 window), [7] write-1 clears gate_missed (not stored).
- All registers, FSM, counters and outputs reset to 0.
- rx_dsp_reset=1: FSM forced to IDLE; decimation and window counters cleared; registers retained.
- Gate path: gate_enable passes through a synchroniser (see Configuration), then an edge-detect flop; rise = g & ~g_d, fall = ~g & g_d.
- FSM states:
  - IDLE: leaves to ARMED when enable_rx=1. Any state returns to IDLE when enable_rx=0 or rx_dsp_reset=1.
  - ARMED: on rise, goes to RUN, zeroes all decimation counters and the window counter.
  - RUN, level mode: on fall, returns to ARMED.
  - RUN, window mode: after WIN channel-0 strobes, goes to DONE and pulses window_done. If WIN=0, stays in RUN until fall, then goes to ARMED with no window_done.
  - DONE: on fall (or gate already low), goes to ARMED.
- Decimation, per channel: a counter of RATE_W bits, effective rate R = max(RATE[c],1).
  - In RUN, a strobe is issued when cnt==0, and cnt reloads R-1; otherwise cnt decrements.
  - R=1 gives a strobe every RUN cycle.
  - Outside RUN, the counter holds 0 and no strobe is issued.
  - A rate write during RUN takes effect at that channel's next reload.
- Window mode, channels with equal rates strobe on identical cycles. The window counts only channel-0 strobes. The WIN-th strobe is emitted, then no more strobes.
- gate_missed sets when a rise occurs in RUN or DONE in window mode. The CTRL[7] clear wins over a simultaneous set.

## Timing
- A register write is visible on outputs the cycle after serial_strobe.
- The strobe_decim register is driven from the registered state and counter.
- With GATE_SYNC_EN, for gate_enable rising before clock edge k:
  - rise is detected at k+2, RUN is entered at k+3, the first strobe is at k+4.
  - gate_active rises at k+3.
- Gate fall detected at cycle j: the last possible strobe is at j+1, and gate_active drops at j+1.
- window_done is asserted the cycle after the WIN-th strobe.

## Configuration
- GATED_DECIM_GATE_SYNC_EN defined: two-flop synchroniser on gate_enable; latencies as in Timing.
- Not defined: gate_enable feeds edge detection directly, for gates already synchronous to master_clk. All gate-related latencies shrink by 2 cycles; first strobe at k+2.

## Structure
- Package gated_decim_pkg holds:
  - register offsets (CTRL_OFS=0, RATE_OFS=1)
  - CTRL bit positions
  - mode constants
  - FSM state typedef (IDLE, ARMED, RUN, DONE)
- Sub-module decim_strobe_ch (one instance per channel) holds the reload counter and strobe register, with inputs run, clear and rate.
- Top level holds the register decode, gate path, FSM and window counter.

## Test plan
- Level mode, RATE0=4, RATE1=2, gate high for 20 cycles:
  - ch0 strobes every 4 cycles, ch1 every 2 cycles, first strobes coincident at k+4.
  - No strobes once gate_active drops.
- Window mode, WIN=5, RATE0=3, gate held high for 100 cycles:
  - exactly 5 ch0 strobes 3 cycles apart, then window_done pulse.
  - FSM stays in DONE until gate falls.
- Window mode, WIN=5, second gate rise during RUN -> gate_missed=1 and the window is not restarted. CTRL write with bit7=1 -> gate_missed=0.
- RATE0=0 and RATE0=1 -> strobe every RUN cycle in both cases.
- rx_dsp_reset written to 1 mid-RUN:
  - strobes stop the next cycle and FSM is IDLE.
  - RATE registers are unchanged on readback via decim_rate.
- Async reset asserted mid-window -> all outputs 0 immediately. Without GATED_DECIM_GATE_SYNC_EN, first strobe at k+2.
